ccff_bitstream_loader: RTL and testbench

//  Upstream driver for configuration-chain memories (e.g. mux_tree_tapbuf_*_mem DFF chains).

---
 rtl/ccff_bitstream_loader.sv | 145 ++++++++++++++
 tb/tb_ccff_bitstream_loader.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ccff_bitstream_loader.sv
// Serializes configuration words MSB-first into a scan-style DFF chain and
// captures the chain tail as readback words holding the previous contents.
module ccff_bitstream_loader #(
  parameter int DATA_W    = 32,
  parameter int CHAIN_LEN = 6,
  parameter int CNT_W     = 16
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic [DATA_W-1:0] rb_data,
  output logic              rb_valid,
  output logic              busy,
  output logic              done,
  output logic              aborted
);

  localparam int WB_W = $clog2(DATA_W) + 1;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] rb_shreg;
  logic [DATA_W-1:0] rb_next;
  logic [CNT_W-1:0]  bit_cnt;
  logic [WB_W-1:0]   word_bit;
  logic [WB_W-1:0]   rb_cnt;
  logic              take;
  logic              emit;
  logic              take_abort;

  // Moves the n_valid captured low bits to the top and zero-fills below.
  function automatic logic [DATA_W-1:0] left_justify(input logic [DATA_W-1:0] w,
                                                     input logic [WB_W-1:0]   n_valid);
    return w << (DATA_W - int'(n_valid));
  endfunction

  always_comb begin
    state_nxt  = state;
    take       = 1'b0;
    emit       = 1'b0;
    take_abort = 1'b0;
    s_ready    = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
        s_ready = !abort;
        if (abort) begin
          take_abort = 1'b1;
          state_nxt  = IDLE;
        end else if (s_valid) begin
          take      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (abort) begin
          take_abort = 1'b1;
          state_nxt  = IDLE;
        end else begin
          emit = 1'b1;
          if (bit_cnt == CNT_W'(CHAIN_LEN - 1))
            state_nxt = DONE;
          else if (word_bit == WB_W'(DATA_W - 1))
            state_nxt = LOAD;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy    = (state == LOAD) || (state == SHIFT);
  assign rb_next = {rb_shreg[DATA_W-2:0], ccff_tail};

  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      state         <= IDLE;
      shreg         <= '0;
      bit_cnt       <= '0;
      word_bit      <= '0;
      ccff_head     <= 1'b0;
      ccff_shift_en <= 1'b0;
      rb_shreg      <= '0;
      rb_cnt        <= '0;
      rb_data       <= '0;
      rb_valid      <= 1'b0;
      done          <= 1'b0;
      aborted       <= 1'b0;
    end else begin
      state         <= state_nxt;
      ccff_shift_en <= emit;
      aborted       <= take_abort;
      done          <= (state == DONE);
      rb_valid      <= 1'b0;

      if (emit) ccff_head <= shreg[DATA_W-1];

      if (take) begin
        shreg    <= s_data;
        word_bit <= '0;
      end else if (emit) begin
        shreg    <= shreg << 1;
        word_bit <= word_bit + 1'b1;
      end

      if (state == IDLE)
        bit_cnt <= '0;
      else if (emit)
        bit_cnt <= bit_cnt + 1'b1;

      // The tail is sampled on the same edge the chain advances; an abort
      // drops the partial readback word.
      if (take_abort) begin
        rb_cnt <= '0;
      end else if (ccff_shift_en) begin
        if (rb_cnt == WB_W'(DATA_W - 1)) begin
          rb_data  <= rb_next;
          rb_valid <= 1'b1;
          rb_cnt   <= '0;
        end else if (state == DONE) begin
          rb_data  <= left_justify(rb_next, rb_cnt + 1'b1);
          rb_valid <= 1'b1;
          rb_cnt   <= '0;
        end else begin
          rb_shreg <= rb_next;
          rb_cnt   <= rb_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Bench for ccff_bitstream_loader: two configurations, each driving a behavioural
// DFF chain, checked against a bit-list reference model of chain contents.
module tb_ccff_bitstream_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic        s_valid;
  logic        sel;
  logic [31:0] s_data;

  logic       ready_a, head_a, se_a, rbv_a, busy_a, done_a, ab_a;
  logic [3:0] rb_a;
  logic       ready_b, head_b, se_b, rbv_b, busy_b, done_b, ab_b;
  logic [7:0] rb_b;

  logic [5:0] chain_a = '0;
  logic [7:0] chain_b = '0;

  int n_assert = 0;
  int n_fail   = 0;
  int dw;
  int cl;
  int mdl[8];
  bit mdl_ok;

  always #5 clk = ~clk;

  ccff_bitstream_loader #(.DATA_W(4), .CHAIN_LEN(6), .CNT_W(16)) dut_a (
    .prog_clk(clk), .prog_reset(rst), .start(start & ~sel), .abort(abort & ~sel),
    .s_data(s_data[3:0]), .s_valid(s_valid), .s_ready(ready_a),
    .ccff_head(head_a), .ccff_shift_en(se_a), .ccff_tail(chain_a[5]),
    .rb_data(rb_a), .rb_valid(rbv_a), .busy(busy_a), .done(done_a), .aborted(ab_a)
  );

  ccff_bitstream_loader #(.DATA_W(8), .CHAIN_LEN(8), .CNT_W(16)) dut_b (
    .prog_clk(clk), .prog_reset(rst), .start(start & sel), .abort(abort & sel),
    .s_data(s_data[7:0]), .s_valid(s_valid), .s_ready(ready_b),
    .ccff_head(head_b), .ccff_shift_en(se_b), .ccff_tail(chain_b[7]),
    .rb_data(rb_b), .rb_valid(rbv_b), .busy(busy_b), .done(done_b), .aborted(ab_b)
  );

  // Downstream chains: head enters mem[0], tail is mem[CHAIN_LEN-1].
  always @(posedge clk) if (se_a) chain_a <= {chain_a[4:0], head_a};
  always @(posedge clk) if (se_b) chain_b <= {chain_b[6:0], head_b};

  wire        obs_ready = sel ? ready_b : ready_a;
  wire        obs_head  = sel ? head_b  : head_a;
  wire        obs_se    = sel ? se_b    : se_a;
  wire        obs_rbv   = sel ? rbv_b   : rbv_a;
  wire        obs_busy  = sel ? busy_b  : busy_a;
  wire        obs_done  = sel ? done_b  : done_a;
  wire        obs_ab    = sel ? ab_b    : ab_a;
  wire [31:0] obs_rb    = sel ? {24'b0, rb_b} : {28'b0, rb_a};
  wire [31:0] obs_chain = sel ? {24'b0, chain_b} : {26'b0, chain_a};
  wire [6:0]  obs_vec   = {obs_ready, obs_head, obs_se, obs_rbv, obs_busy, obs_done, obs_ab};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_val();
    logic [31:0] v = '0;
    for (int k = 0; k < cl; k++) v[k] = mdl[k][0];
    return v;
  endfunction

  task automatic run_load(input logic [31:0] w0, input logic [31:0] w1, input int st0,
                          input int st1, input int abort_k, input int extra_start);
    logic [31:0] words[2];
    int          stalls[2];
    int          r[8];
    logic [31:0] rbq[$];
    logic [31:0] headv, exp_head, expw;
    int nw, n, widx, stall_left, nse, ndone, nab, first_se, done_cyc, last_rb_cyc;
    int tail_cnt, total_stall, exp_nrb, b;
    bit accept_pend, abort_sent;
    words[0] = w0; words[1] = w1;
    stalls = '{st0, st1};
    nw = (cl + dw - 1) / dw;
    n = (abort_k > 0) ? abort_k : cl;
    widx = 0; stall_left = stalls[0]; nse = 0; ndone = 0; nab = 0;
    first_se = -1; done_cyc = -1; last_rb_cyc = -1; tail_cnt = 0; total_stall = 0;
    accept_pend = 0; abort_sent = 0; headv = '0;
    for (int cyc = 0; cyc < 300 && tail_cnt < 4; cyc++) begin
      @(negedge clk);
      if (obs_se) begin
        headv = {headv[30:0], obs_head};
        nse++;
        if (first_se < 0) first_se = cyc;
      end
      if (obs_rbv) begin rbq.push_back(obs_rb); last_rb_cyc = cyc; end
      if (obs_done) begin ndone++; done_cyc = cyc; end
      if (obs_ab) nab++;
      if (ndone > 0 || nab > 0) tail_cnt++;
      if (accept_pend) begin
        widx++;
        if (widx < 2) stall_left = stalls[widx];
      end
      start = (cyc == 0) || (cyc == extra_start);
      abort = 1'b0;
      if (abort_k > 0 && !abort_sent && nse == abort_k) begin
        abort = 1'b1;
        abort_sent = 1;
      end
      s_valid = 1'b0;
      if (widx < nw) begin
        s_data = words[widx];
        if (obs_ready && stall_left > 0) begin
          stall_left--;
          total_stall++;
        end else begin
          s_valid = 1'b1;
        end
      end
      accept_pend = s_valid && obs_ready && !abort;
    end
    start = 1'b0; abort = 1'b0; s_valid = 1'b0;
    check("finished", 32'(tail_cnt >= 4), 32'd1);

    if (abort_k == 0) begin
      check("shift_en_count", nse, cl);
      check("done_count", ndone, 1);
      check("aborted_count", nab, 0);
      check("first_shift_latency", first_se, 3 + st0);
      check("load_latency", done_cyc, cl + nw + 2 + total_stall);
      check("done_with_last_rb", last_rb_cyc, done_cyc);
    end else begin
      check("abort_shift_count", nse, abort_k);
      check("abort_no_done", ndone, 0);
      check("aborted_pulse", nab, 1);
    end

    exp_head = '0;
    for (int i = 0; i < n; i++) exp_head = {exp_head[30:0], words[i / dw][dw - 1 - (i % dw)]};
    check("head_seq", headv, exp_head);

    // Readback: previous contents, mem[CHAIN_LEN-1] first, packed into words.
    for (int j = 0; j < cl; j++) r[j] = mdl[cl - 1 - j];
    exp_nrb = (abort_k > 0) ? (n - 1) / dw : nw;
    if (mdl_ok) begin
      check("rb_count", rbq.size(), exp_nrb);
      for (int w = 0; w < exp_nrb && w < rbq.size(); w++) begin
        expw = '0;
        for (int t = 0; t < dw; t++)
          if (w * dw + t < cl && r[w * dw + t] != 0) expw[dw - 1 - t] = 1'b1;
        check("rb_word", rbq[w], expw);
      end
    end

    for (int i = 0; i < n; i++) begin
      b = int'(words[i / dw][dw - 1 - (i % dw)]);
      for (int k = cl - 1; k > 0; k--) mdl[k] = mdl[k - 1];
      mdl[0] = b;
    end
    if (abort_k == 0) mdl_ok = 1;
    if (mdl_ok) check("chain_contents", obs_chain, model_val());
    check("idle_after", 32'(obs_busy), 32'd0);
  endtask

  initial begin
    sel = 1'b0; dw = 4; cl = 6; mdl_ok = 1;
    for (int k = 0; k < 8; k++) mdl[k] = 0;
    rst = 1'b1; start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = '0;
    repeat (2) @(negedge clk);
    check("reset_outputs_a", {25'b0, obs_vec}, 32'd0);
    check("reset_rb_a", obs_rb, 32'd0);
    check("reset_outputs_b", 32'({ready_b, head_b, se_b, rbv_b, busy_b, done_b, ab_b, rb_b}), 32'd0);
    rst = 1'b0;

    // Basic load, then a reload that returns the first image and ignores a start in DONE.
    run_load(32'hA, 32'hC, 0, 0, 0, -1);
    check("chain_image_1", obs_chain, 32'h2B);
    run_load(32'h0, 32'h0, 0, 0, 0, 9);
    check("chain_cleared", obs_chain, 32'h0);
    // Stall before the second word.
    run_load(32'hA, 32'hC, 0, 5, 0, -1);
    check("chain_image_stall", obs_chain, 32'h2B);
    // Abort after three shifted bits, then a normal load.
    run_load($urandom, $urandom, 0, 0, 3, -1);
    run_load($urandom, $urandom, $urandom_range(0, 2), $urandom_range(0, 2), 0, -1);

    // Asynchronous reset in the middle of shifting.
    @(negedge clk);
    start = 1'b1; s_valid = 1'b1; s_data = $urandom;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1 check("async_reset_outputs", {25'b0, obs_vec}, 32'd0);
    check("async_reset_rb", obs_rb, 32'd0);
    @(negedge clk);
    rst = 1'b0; s_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("no_autostart", 32'(obs_busy), 32'd0);
    mdl_ok = 0;
    run_load($urandom, $urandom, 0, 0, 0, 4);
    run_load($urandom, $urandom, 0, 0, 0, -1);

    for (int it = 0; it < 5; it++)
      run_load($urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0,
               ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 8)) : -1);

    // Single-word configuration: chain length equals word width.
    @(negedge clk);
    sel = 1'b1; dw = 8; cl = 8; mdl_ok = 1;
    for (int k = 0; k < 8; k++) mdl[k] = 0;
    run_load(32'h81, 32'h0, 0, 0, 0, -1);
    check("chain_image_81", obs_chain, 32'h81);
    for (int it = 0; it < 4; it++)
      run_load($urandom, $urandom, $urandom_range(0, 3), 0,
               (it == 2) ? int'($urandom_range(1, 7)) : 0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
